// File: rtl/hssi_rst_seq_pkg.sv
// Shared types and default timing for the HSSI port reset sequencer.
package hssi_rst_seq_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE, S_DONE} rst_state_t;

  localparam int DEF_NUM_PORTS      = 4;
  localparam int DEF_MIN_RST_CYCLES = 16;
  localparam int DEF_ACK_TIMEOUT    = 1024;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hssi_rst_pri_enc.sv
// Lowest-set-bit encoder: index of the lowest request bit, found when any bit is set.
module hssi_rst_pri_enc
  import hssi_rst_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]        req,
  output logic                found,
  output logic [idx_w(W)-1:0] index
);

  localparam int IW = idx_w(W);

  always_comb begin
    found = 1'b0;
    index = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/hssi_port_rst_seq.sv
// Services latched per-port soft-reset requests one port at a time, lowest index first.
// Request to port reset high takes two cycles; all outputs are registered.
module hssi_port_rst_seq
  import hssi_rst_seq_pkg::*;
#(
  parameter int NUM_PORTS      = DEF_NUM_PORTS,
  parameter int MIN_RST_CYCLES = DEF_MIN_RST_CYCLES,
  parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_PORTS-1:0]        i_rst_req,
  input  logic [NUM_PORTS-1:0]        i_rst_ack,
  input  logic [NUM_PORTS-1:0]        i_timeout_clr,
  output logic [NUM_PORTS-1:0]        o_port_rst,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [idx_w(NUM_PORTS)-1:0] o_done_port,
  output logic [NUM_PORTS-1:0]        o_timeout
);

  localparam int PW = idx_w(NUM_PORTS);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT - 1);

  rst_state_t           state;
  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] timeout;
  logic [NUM_PORTS-1:0] port_rst;
  logic [NUM_PORTS-1:0] sel_mask;
  logic [NUM_PORTS-1:0] nxt_mask;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        nxt_idx;
  logic [PW-1:0]        done_port;
  logic [CW-1:0]        cnt;
  logic                 nxt_found;
  logic                 ack_sel;
  logic                 busy;
  logic                 done;

  hssi_rst_pri_enc #(.W(NUM_PORTS)) u_pri_enc (
    .req   (pending),
    .found (nxt_found),
    .index (nxt_idx)
  );

  assign sel_mask = NUM_PORTS'(1) << sel;
  assign nxt_mask = NUM_PORTS'(1) << nxt_idx;
  // Masked reduction keeps acks of unselected ports out of the decision.
  assign ack_sel  = |(i_rst_ack & sel_mask);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      pending   <= '0;
      timeout   <= '0;
      cnt       <= '0;
      sel       <= '0;
      port_rst  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_port <= '0;
    end else begin
      pending   <= pending | i_rst_req;
      timeout   <= timeout & ~i_timeout_clr;
      done      <= 1'b0;
      done_port <= '0;
      case (state)
        S_IDLE: begin
          if (nxt_found) begin
            sel      <= nxt_idx;
            cnt      <= '0;
            port_rst <= nxt_mask;
            busy     <= 1'b1;
            state    <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          cnt <= cnt + 1'b1;
          if (ack_sel && (cnt >= CNT_MIN)) begin
            cnt      <= '0;
            port_rst <= '0;
            state    <= S_RELEASE;
          end else if (cnt == CNT_MAX) begin
            timeout  <= (timeout & ~i_timeout_clr) | sel_mask;
            cnt      <= '0;
            port_rst <= '0;
            state    <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          cnt <= cnt + 1'b1;
          if (!ack_sel) begin
            done      <= 1'b1;
            done_port <= sel;
            state     <= S_DONE;
          end else if (cnt == CNT_MAX) begin
            timeout   <= (timeout & ~i_timeout_clr) | sel_mask;
            done      <= 1'b1;
            done_port <= sel;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // A fresh request for the same port this cycle keeps it pending.
          pending <= (pending & ~sel_mask) | i_rst_req;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_port_rst  = port_rst;
  assign o_busy      = busy;
  assign o_done      = done;
  assign o_done_port = done_port;
  assign o_timeout   = timeout;

endmodule
